// File: rtl/sha256_pkg.sv
// Shared SHA-256 definitions: word type, round constants, sigma functions.
package sha256_pkg;

    typedef logic [31:0] word_t;

    localparam word_t K [64] = '{
        32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5,
        32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
        32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3,
        32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
        32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc,
        32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
        32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7,
        32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
        32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13,
        32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
        32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3,
        32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
        32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5,
        32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
        32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208,
        32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
    };

    function automatic word_t rotr(input word_t x, input int unsigned n);
        return (x >> n) | (x << (32 - n));
    endfunction

    function automatic word_t sigma0(input word_t x);
        return rotr(x, 7) ^ rotr(x, 18) ^ (x >> 3);
    endfunction

    function automatic word_t sigma1(input word_t x);
        return rotr(x, 17) ^ rotr(x, 19) ^ (x >> 10);
    endfunction

    function automatic word_t big_sigma0(input word_t x);
        return rotr(x, 2) ^ rotr(x, 13) ^ rotr(x, 22);
    endfunction

    function automatic word_t big_sigma1(input word_t x);
        return rotr(x, 6) ^ rotr(x, 11) ^ rotr(x, 25);
    endfunction

endpackage

// File: rtl/sha256_wk_sched.sv
// SHA-256 message schedule: streams (W[t] + K[t]) for one block, t = 0..63.
// Define SHA256_WK_REGOUT_EN to register wk (adds one cycle of latency).
module sha256_wk_sched
    import sha256_pkg::*;
#(
    parameter int ROUNDS = 64
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [511:0] blk,
    input  logic         blk_valid,
    output logic         blk_ready,
    output logic [31:0]  wk,
    output logic [5:0]   wk_round,
    output logic         wk_last,
    output logic         wk_valid,
    input  logic         wk_ready
);

    localparam logic [5:0] LAST_T = 6'(ROUNDS - 1);

    typedef enum logic {IDLE, RUN} state_e;

    state_e     state_q, state_d;
    logic [5:0] t_q, t_d;
    word_t      w_q [16];
    word_t      w_d [16];
    logic       accept;
    logic       fire;

`ifdef SHA256_WK_REGOUT_EN
    word_t wk_q, wk_d;
    logic  vld_q, vld_d;
`endif

    always_comb begin
        state_d = state_q;
        t_d     = t_q;
        w_d     = w_q;
        accept  = (state_q == IDLE) && blk_valid;
`ifdef SHA256_WK_REGOUT_EN
        fire    = (state_q == RUN) && vld_q && wk_ready;
`else
        fire    = (state_q == RUN) && wk_ready;
`endif
        if (accept) begin
            for (int i = 0; i < 16; i++) begin
                w_d[i] = blk[511-32*i -: 32];
            end
            t_d     = '0;
            state_d = RUN;
        end else if (fire) begin
            for (int i = 0; i < 15; i++) begin
                w_d[i] = w_q[i+1];
            end
            w_d[15] = sigma1(w_q[14]) + w_q[9] + sigma0(w_q[1]) + w_q[0];
            t_d     = t_q + 6'd1;
            if (t_q == LAST_T) begin
                state_d = IDLE;
            end
        end
    end

`ifdef SHA256_WK_REGOUT_EN
    // First RUN cycle primes the output register; each consume preloads
    // the next word so wk never sees the adder directly.
    always_comb begin
        vld_d = vld_q;
        wk_d  = wk_q;
        if ((state_q == RUN) && !vld_q) begin
            wk_d  = w_q[0] + K[t_q];
            vld_d = 1'b1;
        end else if (fire) begin
            if (t_q == LAST_T) begin
                wk_d  = '0;
                vld_d = 1'b0;
            end else begin
                wk_d = w_q[1] + K[t_d];
            end
        end
    end
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            t_q     <= '0;
`ifdef SHA256_WK_REGOUT_EN
            vld_q   <= 1'b0;
            wk_q    <= '0;
`endif
        end else begin
            state_q <= state_d;
            t_q     <= t_d;
            w_q     <= w_d;
`ifdef SHA256_WK_REGOUT_EN
            vld_q   <= vld_d;
            wk_q    <= wk_d;
`endif
        end
    end

    assign blk_ready = (state_q == IDLE);
    assign wk_round  = t_q;
    assign wk_last   = wk_valid && (t_q == LAST_T);

`ifdef SHA256_WK_REGOUT_EN
    assign wk_valid = vld_q;
    assign wk       = wk_q;
`else
    assign wk_valid = (state_q == RUN);
    assign wk       = wk_valid ? (w_q[0] + K[t_q]) : '0;
`endif

endmodule

// File: tb/tb_sha256_wk_sched.sv
// Directed bench for sha256_wk_sched with a block-level reference model.
// Honours SHA256_WK_REGOUT_EN for the extra output latency.
module tb_sha256_wk_sched;

`ifdef SHA256_WK_REGOUT_EN
    localparam int LAT = 1;
`else
    localparam int LAT = 0;
`endif
    localparam int PERIOD = 65 + LAT;

    localparam logic [31:0] KT [64] = '{
        32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5,
        32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
        32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3,
        32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
        32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc,
        32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
        32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7,
        32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
        32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13,
        32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
        32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3,
        32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
        32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5,
        32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
        32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208,
        32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
    };

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic [511:0] blk = '0;
    logic         blk_valid = 1'b0;
    logic         blk_ready;
    logic [31:0]  wk;
    logic [5:0]   wk_round;
    logic         wk_last;
    logic         wk_valid;
    logic         wk_ready = 1'b1;

    sha256_wk_sched dut (
        .clk       (clk),
        .rst       (rst),
        .blk       (blk),
        .blk_valid (blk_valid),
        .blk_ready (blk_ready),
        .wk        (wk),
        .wk_round  (wk_round),
        .wk_last   (wk_last),
        .wk_valid  (wk_valid),
        .wk_ready  (wk_ready)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    task automatic chk(input string nm, input logic [63:0] got,
                       input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", nm, got, exp);
        end
    endtask

    function automatic logic [31:0] rr(input logic [31:0] x, input int n);
        logic [63:0] d;
        d = {x, x} >> n;
        return d[31:0];
    endfunction

    // Reference: expand the whole schedule, then add the round constants.
    task automatic expand(input logic [511:0] b, output logic [31:0] r [64]);
        logic [31:0] w [64];
        logic [31:0] s0, s1;
        for (int i = 0; i < 16; i++) w[i] = b[511-32*i -: 32];
        for (int i = 16; i < 64; i++) begin
            s0 = rr(w[i-15], 7) ^ rr(w[i-15], 18) ^ (w[i-15] >> 3);
            s1 = rr(w[i-2], 17) ^ rr(w[i-2], 19) ^ (w[i-2] >> 10);
            w[i] = w[i-16] + s0 + w[i-7] + s1;
        end
        for (int i = 0; i < 64; i++) r[i] = w[i] + KT[i];
    endtask

    function automatic logic [511:0] mkblk(input int unsigned seed);
        logic [511:0] b;
        for (int i = 0; i < 16; i++)
            b[511-32*i -: 32] = seed * 32'h9e3779b9 + i * 32'h7f4a7c15;
        return b;
    endfunction

    // Model state: reflects the DUT after the next rising edge.
    logic        mon_en = 1'b0;
    logic        m_run = 1'b0;
    int          m_wait = 0;
    int          m_t = 0;
    logic [31:0] m_ref [64];
    int          blk_no = 0;
    int          beats1 = 0;
    int          lasts1 = 0;
    int          cyc = 0;
    int          acc_cyc [16];
    logic [31:0] got1 [64];
    logic        stall_prev = 1'b0;
    logic [31:0] prev_wk = '0;
    logic        exp_v;

    always @(negedge clk) begin
        cyc++;
        if (mon_en) begin
            exp_v = m_run && (m_wait == 0);
            chk("wk_valid", 64'(wk_valid), 64'(exp_v));
            chk("blk_ready", 64'(blk_ready), 64'(!m_run));
            if (exp_v) begin
                chk("wk", 64'(wk), 64'(m_ref[m_t]));
                chk("wk_round", 64'(wk_round), 64'(m_t));
                chk("wk_last", 64'(wk_last), 64'(m_t == 63));
                if (stall_prev) chk("wk_stable", 64'(wk), 64'(prev_wk));
                if (blk_no == 1) got1[m_t] = wk;
            end else begin
                chk("wk_last_idle", 64'(wk_last), 64'd0);
            end
            stall_prev = exp_v && !wk_ready && !rst;
            prev_wk = wk;
            if (rst) begin
                m_run = 1'b0;
                m_t = 0;
            end else if (!m_run && blk_valid) begin
                m_run = 1'b1;
                m_t = 0;
                m_wait = LAT;
                expand(blk, m_ref);
                acc_cyc[blk_no] = cyc;
                blk_no++;
            end else if (m_run && m_wait > 0) begin
                m_wait--;
            end else if (m_run && wk_ready) begin
                if (blk_no == 1) begin
                    beats1++;
                    if (wk_last) lasts1++;
                end
                if (m_t == 63) m_run = 1'b0;
                else m_t++;
            end
        end
    end

    task automatic cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [511:0] b);
        int n0;
        n0 = blk_no;
        blk = b;
        blk_valid = 1'b1;
        for (int i = 0; i < 200 && blk_no == n0; i++) cycle();
        if (blk_no == n0) chk("accept_timeout", 64'd1, 64'd0);
        blk_valid = 1'b0;
    endtask

    task automatic wait_idle();
        for (int i = 0; i < 2000 && m_run; i++) begin
            cycle();
        end
        if (m_run) chk("idle_timeout", 64'd1, 64'd0);
    endtask

    logic [511:0] abc;
    logic [31:0]  pin [64];
    int           b0;

    initial begin
        abc = '0;
        abc[511:480] = 32'h61626380;
        abc[31:0] = 32'h00000018;

        expand(abc, pin);
        chk("model_r0", 64'(pin[0]), 64'h a3ec9318);
        chk("model_r16", 64'(pin[16]), 64'h 45fdcd41);

        cycle();
        cycle();
        chk("rst_blk_ready", 64'(blk_ready), 64'd1);
        chk("rst_wk_valid", 64'(wk_valid), 64'd0);
        chk("rst_wk_last", 64'(wk_last), 64'd0);
        chk("rst_wk", 64'(wk), 64'd0);
        chk("rst_wk_round", 64'(wk_round), 64'd0);
        rst = 1'b0;
        mon_en = 1'b1;

        // abc, ready high
        send(abc);
        wait_idle();
        chk("beats", 64'(beats1), 64'd64);
        chk("lasts", 64'(lasts1), 64'd1);
        chk("abc_r0", 64'(got1[0]), 64'h a3ec9318);
        chk("abc_r1", 64'(got1[1]), 64'h 71374491);
        chk("abc_r15", 64'(got1[15]), 64'h c19bf18c);
        chk("abc_r16", 64'(got1[16]), 64'h 45fdcd41);

        // abc, random stalls
        blk = abc;
        blk_valid = 1'b1;
        for (int i = 0; i < 3000; i++) begin
            cycle();
            blk_valid = 1'b0;
            wk_ready = 1'($urandom_range(0, 1));
            if (!m_run) break;
        end
        if (m_run) chk("stall_timeout", 64'd1, 64'd0);
        wk_ready = 1'b1;
        cycle();

        // back-to-back, blk_valid held; data changes after first accept
        b0 = blk_no;
        blk = mkblk(3);
        blk_valid = 1'b1;
        for (int i = 0; i < 400 && blk_no < b0 + 2; i++) begin
            cycle();
            if (blk_no == b0 + 1) blk = mkblk(4);
        end
        blk_valid = 1'b0;
        chk("b2b_period", 64'(acc_cyc[b0+1] - acc_cyc[b0]), 64'(PERIOD));
        wait_idle();
        cycle();

        // reset mid-block at round 20
        send(mkblk(5));
        for (int i = 0; i < 200 && !(m_run && m_t == 20 && m_wait == 0); i++)
            cycle();
        chk("mid_round", 64'(wk_round), 64'd20);
        rst = 1'b1;
        cycle();
        rst = 1'b0;
        chk("mid_rst_valid", 64'(wk_valid), 64'd0);
        chk("mid_rst_ready", 64'(blk_ready), 64'd1);
        cycle();

        // reset together with a block offer: nothing accepted
        b0 = blk_no;
        rst = 1'b1;
        blk = mkblk(6);
        blk_valid = 1'b1;
        cycle();
        rst = 1'b0;
        blk_valid = 1'b0;
        chk("rst_wins", 64'(blk_ready), 64'd1);
        chk("rst_wins_cnt", 64'(blk_no), 64'(b0));
        cycle();

        // fresh block after reset, then blk_valid during RUN is ignored
        send(abc);
        for (int i = 0; i < 5; i++) cycle();
        blk = mkblk(7);
        blk_valid = 1'b1;
        for (int i = 0; i < 10; i++) cycle();
        blk_valid = 1'b0;
        wait_idle();
        cycle();
        cycle();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog expired");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/sha256_wk_sched.md
# sha256_wk_sched

SHA-256 message-schedule stage that sits directly upstream of the `efgh` round datapath. It accepts one 512-bit padded message block, expands it into the 64 schedule words W[t], and streams one pre-added word per cycle, (W[t] + K[t]) mod 2^32, to the round stages. It uses a valid/ready handshake on both sides, and the downstream side can stall it.

## Interface
- `ROUNDS`, 64: number of schedule words emitted per block. Only 64 is supported.
- `clk`  in  1  clock; all logic is rising-edge.
- `rst`  in  1  synchronous, active-high reset.
- `blk`  in  512  padded message block; `blk[511:480]` = W0, `blk[31:0]` = W15 (big-endian word order).
- `blk_valid`  in  1  `blk` is valid.
- `blk_ready`  out  1  the block will accept `blk` this cycle.
- `wk`  out  32  (W[t] + K[t]) mod 2^32 for the current round t.
- `wk_round`  out  6  index t of the word currently on `wk`.
- `wk_last`  out  1  high when `wk_round` = 63 and `wk_valid` is high.
- `wk_valid`  out  1  `wk`, `wk_round` and `wk_last` are valid.
- `wk_ready`  in  1  downstream consumes the word this cycle.

## Operation
- Two-state FSM: IDLE and RUN.
- `blk_ready` = (state == IDLE). A block is accepted on `blk_valid && blk_ready`.
  - On acceptance: load W0..W15 into a 16-word shift register `w[0..15]`.
  - Clear round counter `t` to 0.
  - Go to RUN.
- RUN:
  - `wk_valid` = 1 and `wk` = `w[0]` + K[`t`], truncated to 32 bits.
  - A word is consumed on `wk_valid && wk_ready`. On consume:
    - Shift the register: w[i] ← w[i+1].
    - Set w[15] ← σ1(w[14]) + w[9] + σ0(w[1]) + w[0], mod 2^32.
    - Increment `t`.
  - σ0(x) = ROTR7 ^ ROTR18 ^ SHR3.
  - σ1(x) = ROTR17 ^ ROTR19 ^ SHR10.
  - Words expanded for t ≥ 48 are computed but never emitted; this is harmless.
- Consume at t = 63 → go to IDLE, clear `wk_valid`. A new block can then be accepted in the following cycle.
- When `wk_ready` is low, all state and outputs hold unchanged; `wk` must not glitch or change.
- `blk_valid` while in RUN is ignored (`blk_ready` = 0). The upstream holds `blk`.
- `rst` at any cycle, including mid-block:
  - state → IDLE, `t` → 0, `wk_valid` → 0.
  - The partial block is discarded and no further words are emitted.
- No combinational path from `wk_ready` or `blk_valid` to any output except through registered state. `blk_ready` depends on state only.

## Timing
- Reset values: `blk_ready` = 1, `wk_valid` = 0, `wk_last` = 0, `wk` = 0, `wk_round` = 0.
- Latency without REGOUT: the block is accepted at edge N, and `wk_valid` = 1 with round 0 after edge N.
- Throughput: one word per cycle with no stalls.
  - Block period is 64 cycles in RUN plus 1 IDLE cycle = 65 cycles.
- `wk_last` is asserted only together with `wk_valid` at round 63.
- Simultaneous `rst` and block acceptance: `rst` wins and nothing is accepted.

## Configuration
- `SHA256_WK_REGOUT_EN` defined:
  - `wk` comes from a dedicated register preloaded with w[0] + K[t] for the next word, which takes the adder off the output path.
  - First `wk_valid` appears one cycle later (acceptance at edge N → valid after edge N+1).
  - Block period becomes 66 cycles.
  - Stall and reset behaviour are unchanged. `wk` still holds under stall.
- `SHA256_WK_REGOUT_EN` undefined: combinational add from registers, as described in Operation.

## Structure
- Shared package `sha256_pkg`:
  - The K[0..63] constant array.
  - `sigma0`, `sigma1` functions, which are also needed by the round stages (Σ functions live there too).
  - A `word_t` 32-bit typedef.
  - The FSM state enum stays local to this block.
- No sub-module is required. The optional `sha256_sigma` function block is not instantiated; functions from the package are used instead.

## Test plan
- "abc" block: W0 = 0x61626380, W1..W14 = 0, W15 = 0x00000018, with `wk_ready` tied high.
  - Expect round 0 `wk` = 0xa3ec9318.
  - Expect round 1 = 0x71374491.
  - Expect round 15 = 0xc19bf18c.
  - Expect round 16 = 0x45fdcd41.
  - Expect `wk_last` at round 63, 64 beats total.
- Same block with `wk_ready` toggled 0/1 pseudo-randomly: the same 64-value sequence with no drops or duplicates; `wk` stays stable across stall cycles.
- Back-to-back blocks with `blk_valid` held high: `blk_ready` is high exactly one cycle between blocks; the second sequence matches its own reference model.
- Assert `rst` at round 20: the next cycle has `wk_valid` = 0 and `blk_ready` = 1; a fresh block then restarts at round 0 with correct values.
- Drive `blk_valid` during RUN with different data: it is ignored and the current sequence is unaffected.
- Build with `SHA256_WK_REGOUT_EN`: the first valid appears one cycle later and the "abc" values are identical.
